imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and its data-memory (MEM-stage) port.
- Grants one requester at a time, sequences a multi-cycle req/ack transaction to memory, and returns read data with a one-cycle ready pulse.
- The pipeline stalls any stage whose request is high and whose ready is low.
- Sits between the pipelined CPU core and the memory model, replacing the separate instruction and data buses.

Parameters:
- TIMEOUT, 16: max cycles of mem_req without mem_ack before the transaction is aborted with an error.
- CNT_W, 5: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held stable until if_ready or withdrawn by flush.
- if_addr  in  32  fetch address (PC).
- if_rdata  out  32  fetched instruction, valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request (load or store), held stable until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_type  in  3  DMType access width code, passed through unchanged.
- dm_rdata  out  32  load data, valid when dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  memory address, registered.
- mem_wdata  out  32  memory write data, registered.
- mem_type  out  3  access width code, registered; fetch is always word.
- mem_ack  in  1  memory completion, valid for one cycle.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- States: IDLE, BUSY, DONE. Owner register: IF or DM.
- Reset values: every output 0; state IDLE; owner IF; watchdog counter 0.
- IDLE:
  - If dm_req: owner=DM, go BUSY.
  - Else if if_req: owner=IF, go BUSY.
  - Data has fixed priority because it belongs to the older instruction.
  - On entry to BUSY, latch mem_addr, mem_we, mem_wdata and mem_type from the owner. For IF: mem_we=0, mem_type = word code.
- BUSY:
  - mem_req=1.
  - On mem_ack: register mem_rdata into the owner's rdata output, drop mem_req, go DONE.
  - Otherwise increment the watchdog. When it reaches TIMEOUT: set err, drop mem_req, force rdata to 32'h0000_0013 (NOP) for IF or 0 for DM, go DONE.
- DONE:
  - Pulse the owner's ready for exactly one cycle.
  - Suppress the pulse if the owner's req is low in DONE (IF flushed mid-transaction); the memory transaction is still completed.
  - Always return to IDLE. The request must be re-evaluated in IDLE, never in DONE, so a still-high request from the previous owner is not regranted.
- Latency:
  - Request seen in IDLE at cycle 0.
  - mem_req high from cycle 1.
  - mem_ack at cycle k (k ≥ 1).
  - ready at cycle k+1.
  - Next grant is evaluated at cycle k+2.
  - Zero-wait memory (ack in the first BUSY cycle) gives 3 cycles per access.
- Simultaneous if_req and dm_req in IDLE: DM is served first; IF waits.
- mem_ack outside BUSY is ignored.
- mem_rdata, mem_addr and the rdata outputs hold their last value when not being updated.
- Reset mid-transaction: next cycle mem_req=0, state IDLE, ready outputs 0, no pulse.
- Owner request withdrawn during BUSY: keep mem_req asserted until ack or timeout; no abort.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding (IDLE, BUSY, DONE);
  - owner encoding (OWN_IF, OWN_DM);
  - the NOP constant;
  - DMType word constant, shared with the existing encode definitions.
- One sub-module, arb_watchdog:
  - counter with clear/enable inputs, parameterised by TIMEOUT;
  - expired output.

Test Plan:
- Fetch only, ack 2 cycles after mem_req rises, mem_rdata=32'h00500093 → if_ready pulses once at cycle 4 with if_rdata=32'h00500093; mem_addr=if_addr; mem_we=0.
- if_req and dm_req (store, addr 0x100, wdata 0xDEADBEEF) together → store issued first (mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF); dm_ready pulses; fetch is granted two cycles after dm_ready.
- Load, addr 0x40, mem_rdata=0x12345678, zero-wait ack → dm_ready at cycle 2 with dm_rdata=0x12345678; if_ready stays 0 throughout.
- if_req drops while BUSY (flush) → transaction completes on ack; if_ready never pulses; a new fetch is granted normally afterward.
- mem_ack never returns, TIMEOUT=16 → mem_req low after 16 BUSY cycles; err=1 and stays 1; if_ready pulses with if_rdata=0x00000013.
- Reset asserted during BUSY → next cycle mem_req=0, err=0, state IDLE; a stray mem_ack after reset produces no ready pulse.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the instruction/data memory arbiter.
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - owner encoding (OWN_IF, OWN_DM)
//   - NOP instruction returned to fetch after a timeout
//   - DMType word access code, matching the core's encode definitions
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t IDLE = 2'd0;
   localparam arb_state_t BUSY = 2'd1;
   localparam arb_state_t DONE = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   // addi x0, x0, 0 -- harmless filler for a fetch that never completed
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // DMType code for a full 32-bit access; fetches always use it
   localparam logic [2:0] DM_WORD = 3'b000;

endpackage

// File: rtl/arb_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Counts cycles a memory transaction has been waiting for its ack.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : hold the counter at zero (used whenever no transaction waits)
//   enable      : count this cycle (transaction waiting, no ack seen)
//   expired     : high during the TIMEOUT-th waiting cycle
// -----------------------------------------------------------------------------
module arb_watchdog #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Counter starts at zero on the first waiting cycle, so the TIMEOUT-th
   // waiting cycle is the one where count holds TIMEOUT-1.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Flag the expiry combinationally so the owner FSM can abort in that
   // very cycle instead of waiting one extra cycle.
   assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// data-memory port of the pipelined core. One requester is granted at a
// time; data wins ties because it belongs to the older instruction.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   if_req/if_addr             : fetch request and PC
//   if_rdata/if_ready          : fetched instruction and one-cycle done pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_type           : load/store request, DMType width code
//   dm_rdata/dm_ready          : load data and one-cycle done pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_type         : registered request to the memory model
//   mem_ack/mem_rdata          : memory completion and read data
//   err                        : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module imem_dmem_arbiter
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [2:0]  dm_type,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_type,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   arb_state_t state;
   logic       owner;
   logic       wd_expired;
   logic       wd_clear;
   logic       wd_enable;

   assign wd_clear  = (state != BUSY);
   assign wd_enable = (state == BUSY) && !mem_ack;

   arb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Grant / transaction sequencer. Requests are only ever evaluated in
   // IDLE; DONE always falls back to IDLE so a requester that is still high
   // from the transaction just finished cannot be regranted back-to-back
   // ahead of a waiting data request. A fetch grant leaves mem_wdata alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_type  <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dm_req) begin
                  owner     <= OWN_DM;
                  state     <= BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_type  <= dm_type;
               end else if (if_req) begin
                  owner     <= OWN_IF;
                  state     <= BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_type  <= DM_WORD;
               end
            end
            BUSY: begin
               // An ack in the expiry cycle still counts as a normal completion.
               if (mem_ack) begin
                  if (owner == OWN_DM) begin
                     dm_rdata <= mem_rdata;
                  end else begin
                     if_rdata <= mem_rdata;
                  end
                  mem_req <= 1'b0;
                  state   <= DONE;
               end else if (wd_expired) begin
                  if (owner == OWN_DM) begin
                     dm_rdata <= '0;
                  end else begin
                     if_rdata <= NOP_INSN;
                  end
                  err     <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Ready pulses in DONE only while the owner still wants the result, so a
   // fetch flushed mid-transaction completes silently.
   assign if_ready = (state == DONE) && (owner == OWN_IF) && if_req;
   assign dm_ready = (state == DONE) && (owner == OWN_DM) && dm_req;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_dmem_arbiter
// Self-checking bench for imem_dmem_arbiter. A transaction-level reference
// model (grant age in cycles, ack/timeout end point) is compared against the
// DUT on every falling edge; directed scenarios add hand-computed literal
// expectations for latencies and data values.
// -----------------------------------------------------------------------------
module tb_imem_dmem_arbiter;

   localparam int TIMEOUT = 16;

   typedef struct {
      int          rdy_cyc;
      logic [31:0] rdata;
      int          rise_cyc;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [2:0]  mtype;
      int          req_cycles;
      int          other_pulses;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [2:0]  dm_type;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_type;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   imem_dmem_arbiter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_type   (dm_type),
      .dm_rdata  (dm_rdata),
      .dm_ready  (dm_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_type  (mem_type),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Memory model: acks the ack_delay-th cycle of mem_req (0 = never acks).
   // force_ack injects a stray ack regardless of mem_req.
   int          ack_delay = 0;
   logic [31:0] resp_data = '0;
   logic        force_ack = 1'b0;
   int          resp_cnt  = 0;

   always @(posedge clk) begin
      #2;
      if (mem_req && ack_delay != 0) begin
         resp_cnt = resp_cnt + 1;
         mem_ack  = force_ack || (resp_cnt == ack_delay);
      end else begin
         resp_cnt = 0;
         mem_ack  = force_ack;
      end
      mem_rdata = mem_ack ? resp_data : (32'hBAD0_0000 | 32'(resp_cnt));
   end

   // Reference model: a granted transaction is described by its age (cycles
   // since the grant cycle) and whether it has ended (ack or age TIMEOUT).
   // The cycle after the end is the ready cycle; the one after that is free.
   bit          m_valid = 0;
   bit          m_busy  = 0;
   bit          m_dm    = 0;
   bit          m_done  = 0;
   int          m_age   = 0;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
   logic        m_we, m_err;
   logic [2:0]  m_type;

   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("mem_req",   mem_req,   m_busy && !m_done);
         checkOutput("if_ready",  if_ready,  m_busy && m_done && !m_dm && if_req);
         checkOutput("dm_ready",  dm_ready,  m_busy && m_done && m_dm && dm_req);
         checkOutput("mem_addr",  mem_addr,  m_addr);
         checkOutput("mem_we",    mem_we,    m_we);
         checkOutput("mem_wdata", mem_wdata, m_wdata);
         checkOutput("mem_type",  mem_type,  m_type);
         checkOutput("if_rdata",  if_rdata,  m_if_rdata);
         checkOutput("dm_rdata",  dm_rdata,  m_dm_rdata);
         checkOutput("err",       err,       m_err);
      end
      if (reset) begin
         m_valid = 1; m_busy = 0; m_dm = 0; m_done = 0; m_age = 0;
         m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
         m_we = 1'b0; m_err = 1'b0; m_type = '0;
      end else if (m_valid) begin
         if (!m_busy) begin
            if (dm_req || if_req) begin
               m_busy = 1; m_done = 0; m_age = 1; m_dm = dm_req;
               m_addr = dm_req ? dm_addr : if_addr;
               m_we   = dm_req && dm_we;
               m_type = dm_req ? dm_type : 3'b000;
               if (dm_req) m_wdata = dm_wdata;
            end
         end else if (!m_done) begin
            if (mem_ack) begin
               m_done = 1;
               if (m_dm) m_dm_rdata = mem_rdata; else m_if_rdata = mem_rdata;
            end else if (m_age == TIMEOUT) begin
               m_done = 1;
               m_err  = 1'b1;
               if (m_dm) m_dm_rdata = 32'h0; else m_if_rdata = 32'h0000_0013;
            end else begin
               m_age++;
            end
         end else begin
            m_busy = 0;
         end
      end
   end

   task automatic applyStimulus(input bit is_dm, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] dtype,
                                input logic [31:0] resp, input int delay);
      if (is_dm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_type = dtype;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      resp_data = resp;
      ack_delay = delay;
   endtask

   // Follows one transaction from the current cycle until its ready pulse,
   // then withdraws the request at the start of the next cycle.
   task automatic runTxn(input bit is_dm, input int max_cyc, output txn_t r);
      r.rdy_cyc = -1; r.rise_cyc = -1; r.req_cycles = 0; r.other_pulses = 0;
      r.rdata = '0; r.addr = '0; r.we = 1'b0; r.wdata = '0; r.mtype = '0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (mem_req) begin
            r.req_cycles++;
            if (r.rise_cyc < 0) begin
               r.rise_cyc = cyc; r.addr = mem_addr; r.we = mem_we;
               r.wdata = mem_wdata; r.mtype = mem_type;
            end
         end
         if (is_dm ? if_ready : dm_ready) r.other_pulses++;
         if (is_dm ? dm_ready : if_ready) begin
            r.rdy_cyc = cyc;
            r.rdata   = is_dm ? dm_rdata : if_rdata;
            @(posedge clk); #1;
            if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      checks++;
      failures++;
      $display("[TB] FAIL txn_bound: no ready within %0d cycles", max_cyc);
      if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
   endtask

   initial begin
      txn_t r, r2;
      int   t0, pulses, reqs;

      reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; dm_type = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_mem_req", mem_req, 1'b0);
      checkOutput("reset_err", err, 1'b0);
      checkOutput("reset_mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;

      $display("[TB] fetch only, ack on third mem_req cycle");
      applyStimulus(0, 0, 32'h0000_0080, 32'h0, 3'b000, 32'h0050_0093, 3);
      t0 = cyc;
      runTxn(0, 20, r);
      checkOutput("fetch_ready_cycle", 32'(r.rdy_cyc - t0), 32'd4);
      checkOutput("fetch_rdata", r.rdata, 32'h0050_0093);
      checkOutput("fetch_req_rise", 32'(r.rise_cyc - t0), 32'd1);
      checkOutput("fetch_mem_addr", r.addr, 32'h0000_0080);
      checkOutput("fetch_mem_we", r.we, 1'b0);
      checkOutput("fetch_req_cycles", r.req_cycles, 32'd3);
      @(posedge clk); #1;

      $display("[TB] simultaneous store and fetch");
      applyStimulus(0, 0, 32'h0000_0200, 32'h0, 3'b000, 32'h0, 1);
      applyStimulus(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 32'hCAFE_0001, 1);
      t0 = cyc;
      runTxn(1, 20, r);
      checkOutput("store_mem_we", r.we, 1'b1);
      checkOutput("store_mem_addr", r.addr, 32'h0000_0100);
      checkOutput("store_mem_wdata", r.wdata, 32'hDEAD_BEEF);
      checkOutput("store_mem_type", r.mtype, 3'b010);
      checkOutput("store_ready_cycle", 32'(r.rdy_cyc - t0), 32'd2);
      resp_data = 32'h00A0_0113;
      runTxn(0, 20, r2);
      checkOutput("fetch_after_store_gap", 32'(r2.rise_cyc - r.rdy_cyc), 32'd2);
      checkOutput("fetch_after_store_addr", r2.addr, 32'h0000_0200);
      checkOutput("fetch_after_store_type", r2.mtype, 3'b000);
      checkOutput("fetch_after_store_rdata", r2.rdata, 32'h00A0_0113);
      checkOutput("fetch_after_store_ready", 32'(r2.rdy_cyc - t0), 32'd5);
      @(posedge clk); #1;

      $display("[TB] zero-wait load");
      applyStimulus(1, 0, 32'h0000_0040, 32'h0, 3'b100, 32'h1234_5678, 1);
      t0 = cyc;
      runTxn(1, 20, r);
      checkOutput("load_ready_cycle", 32'(r.rdy_cyc - t0), 32'd2);
      checkOutput("load_rdata", r.rdata, 32'h1234_5678);
      checkOutput("load_if_ready_quiet", r.other_pulses, 32'd0);
      checkOutput("load_mem_we", r.we, 1'b0);
      @(posedge clk); #1;

      $display("[TB] fetch flushed while busy");
      applyStimulus(0, 0, 32'h0000_0300, 32'h0, 3'b000, 32'h1111_1111, 3);
      repeat (2) begin @(posedge clk); #1; end
      if_req = 1'b0;
      pulses = 0;
      reqs   = 0;
      repeat (6) begin
         @(negedge clk);
         if (if_ready) pulses++;
         if (mem_req) reqs++;
         @(posedge clk); #1;
      end
      checkOutput("flush_no_ready", pulses, 32'd0);
      checkOutput("flush_req_held", reqs, 32'd2);
      @(negedge clk);
      checkOutput("flush_rdata_completed", if_rdata, 32'h1111_1111);
      @(posedge clk); #1;
      applyStimulus(0, 0, 32'h0000_0304, 32'h0, 3'b000, 32'h0000_0513, 2);
      t0 = cyc;
      runTxn(0, 20, r);
      checkOutput("refetch_ready_cycle", 32'(r.rdy_cyc - t0), 32'd3);
      checkOutput("refetch_rdata", r.rdata, 32'h0000_0513);
      checkOutput("refetch_addr", r.addr, 32'h0000_0304);
      @(posedge clk); #1;

      $display("[TB] fetch timeout");
      applyStimulus(0, 0, 32'h0000_0400, 32'h0, 3'b000, 32'hFFFF_FFFF, 0);
      t0 = cyc;
      runTxn(0, 40, r);
      checkOutput("timeout_req_cycles", r.req_cycles, 32'd16);
      checkOutput("timeout_ready_cycle", 32'(r.rdy_cyc - t0), 32'd17);
      checkOutput("timeout_nop", r.rdata, 32'h0000_0013);
      @(negedge clk);
      checkOutput("timeout_err", err, 1'b1);
      @(posedge clk); #1;
      applyStimulus(1, 0, 32'h0000_0044, 32'h0, 3'b000, 32'h0000_ABCD, 1);
      runTxn(1, 20, r);
      checkOutput("post_timeout_load", r.rdata, 32'h0000_ABCD);
      @(negedge clk);
      checkOutput("err_sticky", err, 1'b1);
      @(posedge clk); #1;

      $display("[TB] reset while busy, then stray ack");
      applyStimulus(0, 0, 32'h0000_0500, 32'h0, 3'b000, 32'h7777_7777, 0);
      repeat (3) begin @(posedge clk); #1; end
      reset  = 1'b1;
      if_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy_mem_req", mem_req, 1'b0);
      checkOutput("rst_busy_err", err, 1'b0);
      checkOutput("rst_busy_if_ready", if_ready, 1'b0);
      @(posedge clk); #1;
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      pulses = 0;
      reqs   = 0;
      repeat (4) begin
         @(negedge clk);
         if (if_ready || dm_ready) pulses++;
         if (mem_req) reqs++;
         @(posedge clk); #1;
      end
      checkOutput("stray_ack_no_ready", pulses, 32'd0);
      checkOutput("stray_ack_no_req", reqs, 32'd0);
      @(negedge clk);
      checkOutput("stray_ack_rdata", if_rdata, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
